udma_cpi_frame_sched: RTL and testbench
=======================================

# udma_cpi_frame_sched

Ping-pong frame scheduler for the CPI camera receive path. It sits between the CPI register file and the uDMA RX channel configuration inputs. For each frame it programs the channel with one of two L2 buffers, arms the channel before start-of-frame, and detects frame completion or corruption. It then alternates buffers and raises per-frame events, so software only services completed buffers.

## Interface
- L2_AWIDTH_NOAL, default 19: width of buffer start addresses.
- TRANS_SIZE, default 20: width of transfer size and bytes-left.
- clk_i  in  1  peripheral clock; every input is synchronous to it.
- rstn_i  in  1  synchronous, active-low reset.
- ctrl_en_i  in  1  level; 1 = run scheduler, 0 = stop/abort.
- buf0_addr_i  in  L2_AWIDTH_NOAL  buffer 0 start address.
- buf1_addr_i  in  L2_AWIDTH_NOAL  buffer 1 start address.
- frame_size_i  in  TRANS_SIZE  bytes per frame.
- frame_cnt_i  in  16  frames to capture; 0 = unlimited.
- frame_start_i  in  1  one-cycle SOF pulse, already synchronised to clk_i.
- frame_end_i  in  1  one-cycle EOF pulse, already synchronised to clk_i.
- ch_en_i  in  1  uDMA channel active.
- ch_pending_i  in  1  uDMA channel has a queued transfer.
- ch_evt_i  in  1  one-cycle channel end-of-transfer event.
- rx_startaddr_o  out  L2_AWIDTH_NOAL  channel start address; registered.
- rx_size_o  out  TRANS_SIZE  channel size; registered.
- rx_continuous_o  out  1  constant 0.
- rx_cen_o  out  1  one-cycle channel enable pulse.
- rx_clr_o  out  1  one-cycle channel clear pulse.
- buf_idx_o  out  1  buffer currently armed or capturing.
- frame_done_o  out  1  one-cycle pulse; a frame has completed into buffer done_idx_o.
- done_idx_o  out  1  buffer index qualified by frame_done_o.
- frame_drop_o  out  1  one-cycle pulse; a frame was corrupted and discarded.
- frames_o  out  16  count of completed frames since leaving IDLE.
- busy_o  out  1  1 whenever the FSM is not in IDLE.

## Operation
- **Reset values.** All outputs are 0, the FSM is in IDLE, and buf_idx is 0.
- **States.** IDLE, ARM, WAIT_SOF, CAPTURE, DONE, CLR.
- **IDLE.**
  - ctrl_en_i=1 → ARM, with buf_idx=0 and frames_o=0.
  - frame_start_i and frame_end_i are ignored.
- **ARM.**
  - Waits while ch_en_i=1 or ch_pending_i=1.
  - Once both are 0: load rx_startaddr_o with the address of buffer buf_idx, load rx_size_o with frame_size_i, and pulse rx_cen_o → WAIT_SOF.
  - ctrl_en_i=0 → CLR.
  - An SOF arriving in ARM is ignored: that frame is skipped, and no drop is signalled.
- **WAIT_SOF.**
  - frame_start_i → CAPTURE.
  - ctrl_en_i=0 → CLR.
  - frame_end_i is ignored (tail of a frame that was already in progress).
- **CAPTURE**, priority highest first:
  - ctrl_en_i=0 → CLR, no event.
  - ch_evt_i → DONE. This takes priority over a frame_end_i or frame_start_i in the same cycle.
  - frame_end_i (short frame) → pulse frame_drop_o → CLR.
  - frame_start_i (missed EOF) → pulse frame_drop_o → CLR.
- **DONE** (one cycle):
  - Pulse frame_done_o, with done_idx_o = buf_idx.
  - frames_o increments, wrapping from 0xFFFF to 0.
  - buf_idx toggles.
  - frame_cnt_i≠0 and the new frames_o equals frame_cnt_i → IDLE; otherwise → ARM.
- **CLR.**
  - Pulse rx_clr_o on entry only.
  - Hold until ch_en_i=0 and ch_pending_i=0.
  - Then ctrl_en_i=1 → ARM with the same buf_idx (the drop retries the same buffer); ctrl_en_i=0 → IDLE.
- **Stability.** rx_startaddr_o and rx_size_o change only on the ARM→WAIT_SOF transition. Changes to buf*_addr_i, frame_size_i or frame_cnt_i therefore take effect at the next arm.

## Timing
- All outputs are registered.
- A pulse caused by a transition from cycle N to N+1 is high only in cycle N+1.
- **ARM.** ARM is seen with the channel idle in cycle N. In cycle N+1: rx_cen_o=1, the new addr/size are valid, and the state is WAIT_SOF.
- **SOF.** frame_start_i in cycle N → CAPTURE in cycle N+1.
- **Completion.**
  - ch_evt_i in cycle N → DONE in cycle N+1, with frame_done_o=1 in that cycle.
  - The next arm pulses rx_cen_o in N+3 at the earliest.
- **Drop.** frame_drop_o and rx_clr_o are asserted in the same cycle.
- **Reset mid-operation.** It takes effect on the next edge: all outputs return to 0 and no clr is issued. Software must clear the channel itself.
- **Stop latency.** ctrl_en_i deasserting reaches CLR in one cycle.

## Test plan
- **Basic run.** buf0=0x100, buf1=0x800, size=64, cnt=3, enable, three frames each ending in ch_evt_i.
  - rx_cen_o pulses three times, with addresses 0x100, 0x800, 0x100.
  - frame_done_o pulses three times, with done_idx_o = 0, 1, 0.
  - frames_o=3, then IDLE and busy_o=0.
- **Short frame.** frame_end_i arrives in CAPTURE with no ch_evt_i.
  - frame_drop_o and rx_clr_o each pulse once.
  - After the channel idles, rx_cen_o re-arms with the same address 0x100 and frames_o is unchanged.
- **Simultaneous events.** ch_evt_i and frame_end_i in the same cycle.
  - frame_done_o=1, frame_drop_o=0, and buf_idx toggles.
- **Busy channel.** ch_pending_i=1 during ARM.
  - No rx_cen_o until it drops.
  - An SOF arriving meanwhile is ignored; capture starts only on the next SOF after the arm.
- **Abort.** ctrl_en_i drops mid-CAPTURE.
  - One rx_clr_o pulse, no done or drop pulse.
  - The FSM waits for ch_en_i=0, then enters IDLE.
- **Unlimited mode.** cnt=0, run 5 frames.
  - The buffer index alternates continuously and frames_o=5.
  - Reset applied in CAPTURE: all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/udma_cpi_frame_sched.sv
// Ping-pong frame scheduler for the CPI receive path: arms the uDMA RX channel
// with alternating L2 buffers and reports completed or corrupted frames.
module udma_cpi_frame_sched #(
  parameter int L2_AWIDTH_NOAL = 19,
  parameter int TRANS_SIZE     = 20
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      ctrl_en_i,
  input  logic [L2_AWIDTH_NOAL-1:0] buf0_addr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] buf1_addr_i,
  input  logic [TRANS_SIZE-1:0]     frame_size_i,
  input  logic [15:0]               frame_cnt_i,
  input  logic                      frame_start_i,
  input  logic                      frame_end_i,
  input  logic                      ch_en_i,
  input  logic                      ch_pending_i,
  input  logic                      ch_evt_i,
  output logic [L2_AWIDTH_NOAL-1:0] rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     rx_size_o,
  output logic                      rx_continuous_o,
  output logic                      rx_cen_o,
  output logic                      rx_clr_o,
  output logic                      buf_idx_o,
  output logic                      frame_done_o,
  output logic                      done_idx_o,
  output logic                      frame_drop_o,
  output logic [15:0]               frames_o,
  output logic                      busy_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    WAIT_SOF = 3'd2,
    CAPTURE  = 3'd3,
    DONE     = 3'd4,
    CLR      = 3'd5
  } state_t;

  state_t state;
  logic   chan_idle;

  assign chan_idle       = !ch_en_i && !ch_pending_i;
  assign rx_continuous_o = 1'b0;

  // Scheduler FSM; every output is registered and pulses are set on the transition edge.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state          <= IDLE;
      rx_startaddr_o <= '0;
      rx_size_o      <= '0;
      rx_cen_o       <= 1'b0;
      rx_clr_o       <= 1'b0;
      buf_idx_o      <= 1'b0;
      frame_done_o   <= 1'b0;
      done_idx_o     <= 1'b0;
      frame_drop_o   <= 1'b0;
      frames_o       <= 16'd0;
      busy_o         <= 1'b0;
    end else begin
      rx_cen_o     <= 1'b0;
      rx_clr_o     <= 1'b0;
      frame_done_o <= 1'b0;
      frame_drop_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_en_i) begin
            state     <= ARM;
            buf_idx_o <= 1'b0;
            frames_o  <= 16'd0;
            busy_o    <= 1'b1;
          end else begin
            busy_o <= 1'b0;
          end
        end
        ARM: begin
          // An SOF seen here is deliberately dropped: the channel is not armed yet.
          if (!ctrl_en_i) begin
            state    <= CLR;
            rx_clr_o <= 1'b1;
          end else if (chan_idle) begin
            rx_startaddr_o <= buf_idx_o ? buf1_addr_i : buf0_addr_i;
            rx_size_o      <= frame_size_i;
            rx_cen_o       <= 1'b1;
            state          <= WAIT_SOF;
          end else begin
            state <= ARM;
          end
        end
        WAIT_SOF: begin
          if (!ctrl_en_i) begin
            state    <= CLR;
            rx_clr_o <= 1'b1;
          end else if (frame_start_i) begin
            state <= CAPTURE;
          end else begin
            state <= WAIT_SOF;
          end
        end
        CAPTURE: begin
          if (!ctrl_en_i) begin
            state    <= CLR;
            rx_clr_o <= 1'b1;
          end else if (ch_evt_i) begin
            state        <= DONE;
            frame_done_o <= 1'b1;
            done_idx_o   <= buf_idx_o;
            frames_o     <= frames_o + 16'd1;
            buf_idx_o    <= ~buf_idx_o;
          end else if (frame_end_i || frame_start_i) begin
            state        <= CLR;
            frame_drop_o <= 1'b1;
            rx_clr_o     <= 1'b1;
          end else begin
            state <= CAPTURE;
          end
        end
        DONE: begin
          if ((frame_cnt_i != 16'd0) && (frames_o == frame_cnt_i)) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            state <= ARM;
          end
        end
        CLR: begin
          // A dropped frame retries the same buffer, so buf_idx is left untouched.
          if (chan_idle) begin
            if (ctrl_en_i) begin
              state <= ARM;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            state <= CLR;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udma_cpi_frame_sched.sv
// Directed self-checking bench for udma_cpi_frame_sched: fixed-latency steps
// with hand-computed expectations and pulse counters sampled on the falling edge.
module tb_udma_cpi_frame_sched;
  logic        clk = 1'b0;
  logic        rstn_i, ctrl_en_i;
  logic [18:0] buf0_addr_i, buf1_addr_i;
  logic [19:0] frame_size_i;
  logic [15:0] frame_cnt_i;
  logic        frame_start_i, frame_end_i, ch_en_i, ch_pending_i, ch_evt_i;
  logic [18:0] rx_startaddr_o;
  logic [19:0] rx_size_o;
  logic        rx_continuous_o, rx_cen_o, rx_clr_o, buf_idx_o;
  logic        frame_done_o, done_idx_o, frame_drop_o, busy_o;
  logic [15:0] frames_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cen_cnt = 0, clr_cnt = 0, done_cnt = 0, drop_cnt = 0;
  int cen0, clr0, done0, drop0;

  always #5 clk = ~clk;

  udma_cpi_frame_sched dut (
    .clk_i(clk), .rstn_i(rstn_i), .ctrl_en_i(ctrl_en_i),
    .buf0_addr_i(buf0_addr_i), .buf1_addr_i(buf1_addr_i),
    .frame_size_i(frame_size_i), .frame_cnt_i(frame_cnt_i),
    .frame_start_i(frame_start_i), .frame_end_i(frame_end_i),
    .ch_en_i(ch_en_i), .ch_pending_i(ch_pending_i), .ch_evt_i(ch_evt_i),
    .rx_startaddr_o(rx_startaddr_o), .rx_size_o(rx_size_o),
    .rx_continuous_o(rx_continuous_o), .rx_cen_o(rx_cen_o), .rx_clr_o(rx_clr_o),
    .buf_idx_o(buf_idx_o), .frame_done_o(frame_done_o), .done_idx_o(done_idx_o),
    .frame_drop_o(frame_drop_o), .frames_o(frames_o), .busy_o(busy_o)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_cen_o)     cen_cnt  <= cen_cnt + 1;
    if (rx_clr_o)     clr_cnt  <= clr_cnt + 1;
    if (frame_done_o) done_cnt <= done_cnt + 1;
    if (frame_drop_o) drop_cnt <= drop_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sof();
    frame_start_i = 1'b1; tick(); frame_start_i = 1'b0;
  endtask

  task automatic pulse_evt();
    ch_evt_i = 1'b1; tick(); ch_evt_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(rx_startaddr_o), 32'd0);
    check({tag, "_size"},  32'(rx_size_o), 32'd0);
    check({tag, "_cont"},  32'(rx_continuous_o), 32'd0);
    check({tag, "_cen"},   32'(rx_cen_o), 32'd0);
    check({tag, "_clr"},   32'(rx_clr_o), 32'd0);
    check({tag, "_buf"},   32'(buf_idx_o), 32'd0);
    check({tag, "_done"},  32'(frame_done_o), 32'd0);
    check({tag, "_didx"},  32'(done_idx_o), 32'd0);
    check({tag, "_drop"},  32'(frame_drop_o), 32'd0);
    check({tag, "_frames"}, 32'(frames_o), 32'd0);
    check({tag, "_busy"},  32'(busy_o), 32'd0);
  endtask

  initial begin
    rstn_i = 1'b0; ctrl_en_i = 1'b0;
    buf0_addr_i = 19'h100; buf1_addr_i = 19'h800;
    frame_size_i = 20'd64; frame_cnt_i = 16'd3;
    frame_start_i = 1'b0; frame_end_i = 1'b0;
    ch_en_i = 1'b0; ch_pending_i = 1'b0; ch_evt_i = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rstn_i = 1'b1;
    tick();

    // Basic run: three frames, addresses 0x100/0x800/0x100
    ctrl_en_i = 1'b1;
    tick();
    check("basic_busy", 32'(busy_o), 32'd1);
    for (int f = 0; f < 3; f++) begin
      tick();
      check("basic_cen",  32'(rx_cen_o), 32'd1);
      check("basic_addr", 32'(rx_startaddr_o), (f % 2 == 1) ? 32'h800 : 32'h100);
      check("basic_size", 32'(rx_size_o), 32'd64);
      pulse_sof();
      pulse_evt();
      check("basic_done",   32'(frame_done_o), 32'd1);
      check("basic_didx",   32'(done_idx_o), 32'(f % 2));
      check("basic_frames", 32'(frames_o), 32'(f + 1));
      tick();
    end
    check("basic_idle_busy",   32'(busy_o), 32'd0);
    check("basic_idle_frames", 32'(frames_o), 32'd3);
    ctrl_en_i = 1'b0;
    tick();
    check("basic_cen_cnt",  32'(cen_cnt), 32'd3);
    check("basic_done_cnt", 32'(done_cnt), 32'd3);

    // Short frame: drop and retry the same buffer
    ctrl_en_i = 1'b1;
    tick();
    tick();
    check("short_arm_addr", 32'(rx_startaddr_o), 32'h100);
    cen0 = cen_cnt; clr0 = clr_cnt; drop0 = drop_cnt; done0 = done_cnt;
    pulse_sof();
    ch_en_i = 1'b1;
    frame_end_i = 1'b1; tick(); frame_end_i = 1'b0;
    check("short_drop", 32'(frame_drop_o), 32'd1);
    check("short_clr",  32'(rx_clr_o), 32'd1);
    tick();
    check("short_clr_once", 32'(rx_clr_o), 32'd0);
    check("short_hold_cen", 32'(rx_cen_o), 32'd0);
    ch_en_i = 1'b0;
    tick();
    tick();
    check("short_rearm_cen",  32'(rx_cen_o), 32'd1);
    check("short_rearm_addr", 32'(rx_startaddr_o), 32'h100);
    check("short_frames",     32'(frames_o), 32'd0);
    check("short_drop_cnt",   32'(drop_cnt - drop0), 32'd1);
    check("short_clr_cnt",    32'(clr_cnt - clr0), 32'd1);
    check("short_done_cnt",   32'(done_cnt - done0), 32'd0);

    // Simultaneous ch_evt and frame_end: completion wins
    pulse_sof();
    ch_evt_i = 1'b1; frame_end_i = 1'b1; tick(); ch_evt_i = 1'b0; frame_end_i = 1'b0;
    check("simul_done", 32'(frame_done_o), 32'd1);
    check("simul_drop", 32'(frame_drop_o), 32'd0);
    check("simul_buf",  32'(buf_idx_o), 32'd1);
    check("simul_frames", 32'(frames_o), 32'd1);

    // Busy channel: arm waits, SOF during ARM is skipped
    ch_pending_i = 1'b1;
    tick();
    tick();
    check("busy_no_cen", 32'(rx_cen_o), 32'd0);
    pulse_sof();
    check("busy_sof_no_cen", 32'(rx_cen_o), 32'd0);
    ch_pending_i = 1'b0;
    tick();
    check("busy_cen",  32'(rx_cen_o), 32'd1);
    check("busy_addr", 32'(rx_startaddr_o), 32'h800);
    pulse_evt();
    check("busy_no_capture", 32'(frame_done_o), 32'd0);
    pulse_sof();
    pulse_evt();
    check("busy_done",   32'(frame_done_o), 32'd1);
    check("busy_didx",   32'(done_idx_o), 32'd1);
    check("busy_frames", 32'(frames_o), 32'd2);
    tick();

    // Abort mid-capture
    tick();
    check("abort_addr", 32'(rx_startaddr_o), 32'h100);
    pulse_sof();
    clr0 = clr_cnt; drop0 = drop_cnt; done0 = done_cnt;
    ch_en_i = 1'b1;
    ctrl_en_i = 1'b0;
    tick();
    check("abort_clr",  32'(rx_clr_o), 32'd1);
    check("abort_drop", 32'(frame_drop_o), 32'd0);
    check("abort_done", 32'(frame_done_o), 32'd0);
    tick();
    check("abort_wait_busy", 32'(busy_o), 32'd1);
    ch_en_i = 1'b0;
    tick();
    check("abort_idle_busy", 32'(busy_o), 32'd0);
    tick();
    check("abort_clr_cnt",  32'(clr_cnt - clr0), 32'd1);
    check("abort_drop_cnt", 32'(drop_cnt - drop0), 32'd0);
    check("abort_done_cnt", 32'(done_cnt - done0), 32'd0);

    // Unlimited mode: five frames, alternating buffers
    frame_cnt_i = 16'd0;
    ctrl_en_i = 1'b1;
    tick();
    for (int f = 0; f < 5; f++) begin
      tick();
      check("unl_addr", 32'(rx_startaddr_o), (f % 2 == 1) ? 32'h800 : 32'h100);
      pulse_sof();
      pulse_evt();
      check("unl_didx",   32'(done_idx_o), 32'(f % 2));
      check("unl_frames", 32'(frames_o), 32'(f + 1));
      tick();
    end
    check("unl_frames5", 32'(frames_o), 32'd5);
    check("unl_busy",    32'(busy_o), 32'd1);
    check("unl_buf",     32'(buf_idx_o), 32'd1);

    // Reset while capturing
    tick();
    pulse_sof();
    ch_en_i = 1'b1;
    rstn_i = 1'b0;
    tick();
    check_all_zero("rst_cap");
    rstn_i = 1'b1; ctrl_en_i = 1'b0; ch_en_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
